// File: rtl/tlb_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_array_pkg
// Description : Shared definitions for the joint TLB: entry field positions,
//               entry width, TLBP miss encoding, page record and page select.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_array_pkg;

  localparam int ENTRY_W  = 78;
  localparam int VPN2_HI  = 77;
  localparam int VPN2_LO  = 59;
  localparam int ASID_HI  = 58;
  localparam int ASID_LO  = 51;
  localparam int G_BIT    = 50;
  localparam int PFN0_HI  = 49;
  localparam int PFN0_LO  = 30;
  localparam int C0_HI    = 29;
  localparam int C0_LO    = 27;
  localparam int D0_BIT   = 26;
  localparam int V0_BIT   = 25;
  localparam int PFN1_HI  = 24;
  localparam int PFN1_LO  = 5;
  localparam int C1_HI    = 4;
  localparam int C1_LO    = 2;
  localparam int D1_BIT   = 1;
  localparam int V1_BIT   = 0;

  localparam logic [31:0] TLBP_MISS = 32'h8000_0000;

  // One page half of an entry, same bit order as stored.
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  // Pick the odd or even page out of the low 50 bits of an entry.
  function automatic page_t select_page(input logic [PFN0_HI:0] pages,
                                        input logic             odd);
    page_t p;
    if (odd) p = page_t'(pages[PFN1_HI:V1_BIT]);
    else     p = page_t'(pages[PFN0_HI:V0_BIT]);
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_match.sv
`default_nettype none
// ============================================================================
// Module      : tlb_match
// Description : Combinational compare of a key against every TLB entry, with
//               a lowest-index-wins priority encoder.
//   ent_vpn2/ent_asid/ent_g : per-entry tag fields
//   vpn2/asid               : lookup key
//   found/index             : hit flag and winning entry index (0 on miss)
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_match #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic [TLBNUM-1:0][18:0] ent_vpn2,
  input  logic [TLBNUM-1:0][7:0]  ent_asid,
  input  logic [TLBNUM-1:0]       ent_g,
  input  logic [18:0]             vpn2,
  input  logic [7:0]              asid,
  output logic                    found,
  output logic [IDXW-1:0]         index
);

  logic [TLBNUM-1:0] hit;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_cmp
    assign hit[i] = (ent_vpn2[i] == vpn2) && (ent_g[i] || (ent_asid[i] == asid));
  end

  // Scan downwards so the last assignment is the lowest hitting index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        index = IDXW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tlb_array
// Description : Fully-associative joint TLB beside CP0. Two registered
//               translation ports (s0 fetch, s1 data), TLBP probe, TLBR read
//               and TLBWI write. All results appear one cycle after request.
//   s*_req/vpn2/odd/asid -> s*_rvalid/found/index/pfn/c/d/v
//   tlbp_req/entryhi     -> tlbp_wen/tlbp_index
//   tlbr_req/tlb_index   -> tlbr_wen/tlbr_entry
//   tlbwi_wen/tlbwi_entry/tlb_index : entry write
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_array
  import tlb_array_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW  = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_req,
  input  logic [18:0]        s0_vpn2,
  input  logic               s0_odd,
  input  logic [7:0]         s0_asid,
  output logic               s0_rvalid,
  output logic               s0_found,
  output logic [IDXW-1:0]    s0_index,
  output logic [19:0]        s0_pfn,
  output logic [2:0]         s0_c,
  output logic               s0_d,
  output logic               s0_v,
  input  logic               s1_req,
  input  logic [18:0]        s1_vpn2,
  input  logic               s1_odd,
  input  logic [7:0]         s1_asid,
  output logic               s1_rvalid,
  output logic               s1_found,
  output logic [IDXW-1:0]    s1_index,
  output logic [19:0]        s1_pfn,
  output logic [2:0]         s1_c,
  output logic               s1_d,
  output logic               s1_v,
  input  logic               tlbp_req,
  input  logic [31:0]        tlbp_entryhi,
  output logic               tlbp_wen,
  output logic [31:0]        tlbp_index,
  input  logic               tlbr_req,
  input  logic [IDXW-1:0]    tlb_index,
  output logic               tlbr_wen,
  output logic [ENTRY_W-1:0] tlbr_entry,
  input  logic               tlbwi_wen,
  input  logic [ENTRY_W-1:0] tlbwi_entry
);

  logic [TLBNUM-1:0][ENTRY_W-1:0] entry_q, entry_d;
  logic [TLBNUM-1:0][18:0]        ent_vpn2;
  logic [TLBNUM-1:0][7:0]         ent_asid;
  logic [TLBNUM-1:0]              ent_g;

  logic            s0_hit, s1_hit, p_hit;
  logic [IDXW-1:0] s0_hit_idx, s1_hit_idx, p_hit_idx;

  logic            s0_rvalid_q, s0_rvalid_d, s0_found_q, s0_found_d;
  logic [IDXW-1:0] s0_index_q, s0_index_d;
  page_t           s0_page_q, s0_page_d;
  logic            s1_rvalid_q, s1_rvalid_d, s1_found_q, s1_found_d;
  logic [IDXW-1:0] s1_index_q, s1_index_d;
  page_t           s1_page_q, s1_page_d;
  logic               tlbp_wen_q, tlbp_wen_d;
  logic [31:0]        tlbp_index_q, tlbp_index_d;
  logic               tlbr_wen_q, tlbr_wen_d;
  logic [ENTRY_W-1:0] tlbr_entry_q, tlbr_entry_d;

  // EntryHi bits [12:8] are reserved and play no part in the probe.
  logic unused_entryhi;
  assign unused_entryhi = ^tlbp_entryhi[12:8];

  for (genvar i = 0; i < TLBNUM; i++) begin : g_fields
    assign ent_vpn2[i] = entry_q[i][VPN2_HI:VPN2_LO];
    assign ent_asid[i] = entry_q[i][ASID_HI:ASID_LO];
    assign ent_g[i]    = entry_q[i][G_BIT];
  end

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_s0 (
    .ent_vpn2(ent_vpn2), .ent_asid(ent_asid), .ent_g(ent_g),
    .vpn2(s0_vpn2), .asid(s0_asid), .found(s0_hit), .index(s0_hit_idx)
  );
  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_s1 (
    .ent_vpn2(ent_vpn2), .ent_asid(ent_asid), .ent_g(ent_g),
    .vpn2(s1_vpn2), .asid(s1_asid), .found(s1_hit), .index(s1_hit_idx)
  );
  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_p (
    .ent_vpn2(ent_vpn2), .ent_asid(ent_asid), .ent_g(ent_g),
    .vpn2(tlbp_entryhi[31:13]), .asid(tlbp_entryhi[7:0]),
    .found(p_hit), .index(p_hit_idx)
  );

  // All reads use entry_q, so anything sampled alongside a TLBWI sees the
  // pre-write contents.
  always_comb begin
    entry_d = entry_q;
    if (tlbwi_wen) entry_d[tlb_index] = tlbwi_entry;

    s0_rvalid_d = s0_req;
    s0_found_d  = s0_found_q;
    s0_index_d  = s0_index_q;
    s0_page_d   = s0_page_q;
    if (s0_req) begin
      s0_found_d = s0_hit;
      s0_index_d = s0_hit_idx;
      s0_page_d  = s0_hit ? select_page(entry_q[s0_hit_idx][PFN0_HI:0], s0_odd) : '0;
    end

    s1_rvalid_d = s1_req;
    s1_found_d  = s1_found_q;
    s1_index_d  = s1_index_q;
    s1_page_d   = s1_page_q;
    if (s1_req) begin
      s1_found_d = s1_hit;
      s1_index_d = s1_hit_idx;
      s1_page_d  = s1_hit ? select_page(entry_q[s1_hit_idx][PFN0_HI:0], s1_odd) : '0;
    end

    tlbp_wen_d   = tlbp_req;
    tlbp_index_d = tlbp_index_q;
    if (tlbp_req) tlbp_index_d = p_hit ? {{(32-IDXW){1'b0}}, p_hit_idx} : TLBP_MISS;

    // A simultaneous TLBP wins the single commit slot.
    tlbr_wen_d   = tlbr_req && !tlbp_req;
    tlbr_entry_d = tlbr_entry_q;
    if (tlbr_wen_d) tlbr_entry_d = entry_q[tlb_index];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q      <= '0;
      s0_rvalid_q  <= 1'b0;
      s0_found_q   <= 1'b0;
      s0_index_q   <= '0;
      s0_page_q    <= '0;
      s1_rvalid_q  <= 1'b0;
      s1_found_q   <= 1'b0;
      s1_index_q   <= '0;
      s1_page_q    <= '0;
      tlbp_wen_q   <= 1'b0;
      tlbp_index_q <= '0;
      tlbr_wen_q   <= 1'b0;
      tlbr_entry_q <= '0;
    end else begin
      entry_q      <= entry_d;
      s0_rvalid_q  <= s0_rvalid_d;
      s0_found_q   <= s0_found_d;
      s0_index_q   <= s0_index_d;
      s0_page_q    <= s0_page_d;
      s1_rvalid_q  <= s1_rvalid_d;
      s1_found_q   <= s1_found_d;
      s1_index_q   <= s1_index_d;
      s1_page_q    <= s1_page_d;
      tlbp_wen_q   <= tlbp_wen_d;
      tlbp_index_q <= tlbp_index_d;
      tlbr_wen_q   <= tlbr_wen_d;
      tlbr_entry_q <= tlbr_entry_d;
    end
  end

  assign s0_rvalid  = s0_rvalid_q;
  assign s0_found   = s0_found_q;
  assign s0_index   = s0_index_q;
  assign s0_pfn     = s0_page_q.pfn;
  assign s0_c       = s0_page_q.c;
  assign s0_d       = s0_page_q.d;
  assign s0_v       = s0_page_q.v;
  assign s1_rvalid  = s1_rvalid_q;
  assign s1_found   = s1_found_q;
  assign s1_index   = s1_index_q;
  assign s1_pfn     = s1_page_q.pfn;
  assign s1_c       = s1_page_q.c;
  assign s1_d       = s1_page_q.d;
  assign s1_v       = s1_page_q.v;
  assign tlbp_wen   = tlbp_wen_q;
  assign tlbp_index = tlbp_index_q;
  assign tlbr_wen   = tlbr_wen_q;
  assign tlbr_entry = tlbr_entry_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_array
// Description : Directed self-checking bench for tlb_array (TLBNUM = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_req = 0, s0_odd = 0, s1_req = 0, s1_odd = 0;
  logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0;
  logic [7:0]  s0_asid = '0, s1_asid = '0;
  logic        s0_rvalid, s0_found, s0_d, s0_v, s1_rvalid, s1_found, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        tlbp_req = 0, tlbr_req = 0, tlbwi_wen = 0;
  logic [31:0] tlbp_entryhi = '0;
  logic        tlbp_wen, tlbr_wen;
  logic [31:0] tlbp_index;
  logic [3:0]  tlb_index = '0;
  logic [77:0] tlbr_entry, tlbwi_entry = '0;

  int checks = 0;
  int failures = 0;

  logic [77:0] e3, e3g, e3b, e1, e7, e2;

  tlb_array #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
    .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index),
    .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
    .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index),
    .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbp_req(tlbp_req), .tlbp_entryhi(tlbp_entryhi), .tlbp_wen(tlbp_wen),
    .tlbp_index(tlbp_index), .tlbr_req(tlbr_req), .tlb_index(tlb_index),
    .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry),
    .tlbwi_wen(tlbwi_wen), .tlbwi_entry(tlbwi_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable when this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                     input logic g, input logic [19:0] pfn0,
                                     input logic [2:0] c0, input logic d0, input logic v0,
                                     input logic [19:0] pfn1, input logic [2:0] c1,
                                     input logic d1, input logic v1);
    return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  task automatic write(input logic [3:0] idx, input logic [77:0] e);
    tlbwi_wen = 1; tlb_index = idx; tlbwi_entry = e;
    tick();
    tlbwi_wen = 0;
  endtask

  initial begin
    e3  = mk(19'h12345, 8'h05, 1'b0, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'hBBBBB, 3'd5, 1'b0, 1'b1);
    e3g = mk(19'h12345, 8'h05, 1'b1, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'hBBBBB, 3'd5, 1'b0, 1'b1);
    e1  = mk(19'h12345, 8'h05, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b1, 20'h11112, 3'd2, 1'b0, 1'b1);
    e7  = mk(19'h12345, 8'h05, 1'b0, 20'h77777, 3'd7, 1'b1, 1'b1, 20'h77778, 3'd7, 1'b1, 1'b1);
    e2  = mk(19'h0ABCD, 8'h05, 1'b0, 20'h22222, 3'd1, 1'b1, 1'b0, 20'h22223, 3'd1, 1'b0, 1'b0);
    e3b = mk(19'h00777, 8'h09, 1'b0, 20'hCCCCC, 3'd6, 1'b1, 1'b1, 20'hDDDDD, 3'd4, 1'b1, 1'b0);

    tick(); tick();
    check("rst_s0_rvalid", 78'(s0_rvalid), 78'd0);
    check("rst_s1_rvalid", 78'(s1_rvalid), 78'd0);
    check("rst_tlbp_wen", 78'(tlbp_wen), 78'd0);
    check("rst_tlbr_wen", 78'(tlbr_wen), 78'd0);
    check("rst_tlbp_index", 78'(tlbp_index), 78'd0);
    rst = 0;
    tick();

    // Lookup into an empty TLB.
    s0_req = 1; s0_vpn2 = 19'h00001;
    tick();
    s0_req = 0;
    check("empty_rvalid", 78'(s0_rvalid), 78'd1);
    check("empty_found", 78'(s0_found), 78'd0);
    check("empty_fields", 78'({s0_index, s0_pfn, s0_c, s0_d, s0_v}), 78'd0);
    tick();
    check("rvalid_pulse", 78'(s0_rvalid), 78'd0);

    // Write idx 3, look up both pages on both ports.
    write(4'd3, e3);
    s0_req = 1; s0_vpn2 = 19'h12345; s0_odd = 0; s0_asid = 8'h05;
    s1_req = 1; s1_vpn2 = 19'h12345; s1_odd = 1; s1_asid = 8'h05;
    tick();
    s0_req = 0; s1_req = 0;
    check("s0_even_hit", 78'({s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}),
          78'({1'b1, 1'b1, 4'd3, 20'hAAAAA, 3'd3, 1'b1, 1'b1}));
    check("s1_odd_hit", 78'({s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}),
          78'({1'b1, 1'b1, 4'd3, 20'hBBBBB, 3'd5, 1'b0, 1'b1}));
    tick();
    check("s1_hold", 78'({s1_rvalid, s1_found, s1_index, s1_pfn}),
          78'({1'b0, 1'b1, 4'd3, 20'hBBBBB}));
    s1_req = 1; s1_asid = 8'h06;
    tick();
    s1_req = 0;
    check("s1_asid_miss", 78'({s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}),
          78'({1'b1, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0}));

    // Probe hit then miss.
    tlbp_req = 1; tlbp_entryhi = 32'h2468_A005;
    tick();
    tlbp_req = 0;
    check("tlbp_hit_wen", 78'(tlbp_wen), 78'd1);
    check("tlbp_hit_index", 78'(tlbp_index), 78'd3);
    tick();
    check("tlbp_wen_pulse", 78'(tlbp_wen), 78'd0);
    tlbp_req = 1; tlbp_entryhi = 32'h0000_2005;
    tick();
    tlbp_req = 0;
    check("tlbp_miss_index", 78'(tlbp_index), 78'(32'h8000_0000));

    // Global bit ignores ASID.
    write(4'd3, e3g);
    s1_req = 1; s1_vpn2 = 19'h12345; s1_odd = 0; s1_asid = 8'hFF;
    tick();
    s1_req = 0;
    check("global_hit", 78'({s1_found, s1_index, s1_pfn}), 78'({1'b1, 4'd3, 20'hAAAAA}));

    // Multiple hits: lowest index wins.
    write(4'd7, e7);
    write(4'd1, e1);
    s0_req = 1; s0_vpn2 = 19'h12345; s0_odd = 0; s0_asid = 8'h05;
    tick();
    s0_req = 0;
    check("multi_hit_lowest", 78'({s0_found, s0_index, s0_pfn}), 78'({1'b1, 4'd1, 20'h11111}));

    // Lookup on the same edge as the write sees old contents.
    tlbwi_wen = 1; tlb_index = 4'd2; tlbwi_entry = e2;
    s0_req = 1; s0_vpn2 = 19'h0ABCD; s0_odd = 0; s0_asid = 8'h05;
    tick();
    tlbwi_wen = 0;
    check("same_edge_miss", 78'({s0_rvalid, s0_found}), 78'({1'b1, 1'b0}));
    tick();
    s0_req = 0;
    check("next_edge_hit", 78'({s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}),
          78'({1'b1, 1'b1, 4'd2, 20'h22222, 3'd1, 1'b1, 1'b0}));

    // TLBR plain, then TLBR alongside a write to the same index.
    tlbr_req = 1; tlb_index = 4'd3;
    tick();
    tlbr_req = 0;
    check("tlbr_wen", 78'(tlbr_wen), 78'd1);
    check("tlbr_entry", tlbr_entry, e3g);
    tlbr_req = 1; tlbwi_wen = 1; tlbwi_entry = e3b;
    tick();
    tlbwi_wen = 0;
    check("tlbr_same_edge_old", tlbr_entry, e3g);
    tick();
    tlbr_req = 0;
    check("tlbr_after_write", tlbr_entry, e3b);
    tick();
    check("tlbr_wen_pulse", 78'(tlbr_wen), 78'd0);

    // TLBP and TLBR together: TLBP wins, idx1 is now the lowest hit.
    tlbp_req = 1; tlbp_entryhi = 32'h2468_A005; tlbr_req = 1; tlb_index = 4'd7;
    tick();
    tlbp_req = 0; tlbr_req = 0;
    check("both_tlbp_wen", 78'(tlbp_wen), 78'd1);
    check("both_tlbr_wen", 78'(tlbr_wen), 78'd0);
    check("both_tlbp_index", 78'(tlbp_index), 78'd1);

    // Reset during a pending result.
    s0_req = 1; s0_vpn2 = 19'h0ABCD; s0_asid = 8'h05;
    tick();
    s0_req = 0;
    check("pre_rst_rvalid", 78'(s0_rvalid), 78'd1);
    rst = 1;
    #1;
    check("rst_drops_rvalid", 78'({s0_rvalid, s0_found, s0_index, s0_pfn}), 78'd0);
    tick();
    rst = 0;
    s0_req = 1; s0_vpn2 = 19'h12345; s0_asid = 8'h05;
    tlbr_req = 1; tlb_index = 4'd1;
    tick();
    s0_req = 0; tlbr_req = 0;
    check("post_rst_miss", 78'({s0_rvalid, s0_found}), 78'({1'b1, 1'b0}));
    check("post_rst_entry", tlbr_entry, 78'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlb_array.md
Name: tlb_array

Overview:
- Fully-associative joint TLB, sitting directly beside the CP0 register block.
- Consumes the TLBWI entry and the TLBR index that CP0 drives.
- Produces the TLBP index result and the TLBR entry that CP0 latches.
- Also serves two registered translation lookups: port 0 for instruction fetch, port 1 for data access (EX stage).

Parameters:
TLBNUM, 16, number of entries (power of two, 2..64)
IDXW, $clog2(TLBNUM), index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s0_req  in  1  fetch lookup request
s0_vpn2  in  19  VA[31:13]
s0_odd  in  1  VA[12], selects odd page
s0_asid  in  8  current ASID
s0_rvalid  out  1  result valid, one cycle after s0_req
s0_found  out  1  hit
s0_index  out  IDXW  hit entry index
s0_pfn  out  20  physical frame number
s0_c  out  3  cache attribute
s0_d  out  1  dirty bit
s0_v  out  1  valid bit
s1_req, s1_vpn2, s1_odd, s1_asid, s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  same widths and meaning as port 0, data port
tlbp_req  in  1  TLBP commit pulse
tlbp_entryhi  in  32  CP0 EntryHi: VPN2 in [31:13], ASID in [7:0]
tlbp_wen  out  1  one-cycle pulse; CP0 writes Index
tlbp_index  out  32  {P, 31'b0 | index}
tlbr_req  in  1  TLBR commit pulse
tlb_index  in  IDXW  entry to read or write
tlbr_wen  out  1  one-cycle pulse; CP0 loads EntryHi/Lo
tlbr_entry  out  78  entry read
tlbwi_wen  in  1  TLBWI commit pulse
tlbwi_entry  in  78  entry to write

Behaviour:
- Entry format, 78 bits, MSB first:
  - vpn2[77:59], asid[58:51], g[50]
  - even page [49:25] = {pfn0[49:30], c0[29:27], d0[26], v0[25]}
  - odd page [24:0] = {pfn1[24:5], c1[4:2], d1[1], v1[0]}
- Storage: TLBNUM x 78 flops. Async rst clears all entries to 0 and all outputs to 0. Reset mid-lookup drops the pending result (rvalid = 0).
- Match(e, vpn2, asid) = (e.vpn2 == vpn2) && (e.g || e.asid == asid).
  - Multiple hits: lowest index wins. Software must prevent this; the bench checks the rule only.
- Lookup ports 0 and 1 are independent and registered, with 1-cycle latency:
  - Edge N samples req/vpn2/odd/asid and evaluates against array contents before edge N's write.
  - s*_rvalid = 1 during cycle N+1 only. Back-to-back requests yield back-to-back results.
  - On hit: pfn/c/d/v come from the odd page if odd = 1, else the even page; found = 1.
  - On miss: found = 0, index/pfn/c/d/v = 0.
  - When rvalid = 0, the other result outputs hold their previous values.
- TLBWI: on an edge with tlbwi_wen, entry[tlb_index] <= tlbwi_entry. The write is visible to any lookup, TLBP or TLBR sampled at the next edge or later.
- Same-edge conflicts:
  - A lookup, TLBP or TLBR sampled on the same edge as a TLBWI sees the old contents.
  - TLBR at the index being written returns the old entry.
- TLBP: edge N samples tlbp_req with tlbp_entryhi. During cycle N+1:
  - tlbp_wen = 1.
  - tlbp_index = {1'b0, zero-extended hit index} on hit, or 32'h8000_0000 on miss.
- TLBR: edge N samples tlbr_req with tlb_index. During cycle N+1, tlbr_wen = 1 and tlbr_entry = entry[tlb_index].
- tlbp_req and tlbr_req are mutually exclusive (single WB commit). If both are high, TLBP takes priority and tlbr_wen stays 0.
- tlb_index >= TLBNUM is impossible by width; no wrap handling is needed.

Decomposition:
- Shared package/header (mycpu.h): TLB entry field bit positions (VPN2_HI/LO, ASID, G, PFN0, C0, D0, V0, PFN1, C1, D1, V1), entry width 78, TLBP miss constant 32'h8000_0000.
- One sub-module, tlb_match: combinational compare of all entries plus lowest-index priority encoder → {found, index}. Instantiated three times (s0, s1, tlbp).

Test Plan:
- Reset, then s0_req with vpn2 = 19'h00001 → next cycle s0_rvalid = 1, s0_found = 0, all fields 0.
- TLBWI idx 3: vpn2 = 19'h12345, asid = 8'h05, g = 0, pfn0 = 20'hAAAAA, c0 = 3, d0 = 1, v0 = 1, pfn1 = 20'hBBBBB. Next cycle, s1 lookup with odd = 1, asid 05 → found = 1, index = 3, pfn = 20'hBBBBB. Same lookup with asid 06 → miss.
- Set g = 1 at idx 3 and lookup with asid 8'hFF → hit. Load vpn2 12345 into idx 1 and idx 7 → index = 1 (lowest wins).
- TLBWI idx 2 and s0_req for the same vpn2 on the same edge → miss. Repeat the request one cycle later → hit.
- tlbp_req with entryhi 32'h2468_A005 against idx 3 (vpn2 12345, asid 05) → tlbp_wen pulse, tlbp_index = 3. With an absent VPN → 32'h8000_0000.
- tlbr_req idx 3 → tlbr_wen one cycle later and tlbr_entry equals the written 78-bit value. Assert rst while a lookup is pending → rvalid = 0 and all entries cleared.
